// File: rtl/dcache_axi_bridge_pkg.sv
// Shared definitions for the data-cache to AXI single-beat bridge:
// FSM state encoding, AXI burst/response codes and cache access sizes.
package dcache_axi_bridge_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RD_ADDR = 3'd1,
      S_RD_DATA = 3'd2,
      S_WR_ADDR = 3'd3,
      S_WR_RESP = 3'd4
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY      = 2'b00;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/dcache_axi_bridge.sv
// Turns one data-cache memory request into a single-beat AXI read or write
// transaction; one outstanding transaction, s_ready pulses on completion.
module dcache_axi_bridge
   import dcache_axi_bridge_pkg::*;
#(
   parameter int         A_WIDTH = 32,
   parameter logic [3:0] AXI_ID  = 4'd1
) (
   input  logic               clk,
   input  logic               clrn,
   input  logic [A_WIDTH-1:0] s_a,
   input  logic [31:0]        s_din,
   output logic [31:0]        s_dout,
   input  logic               s_strobe,
   input  logic               s_rw,
   input  logic [3:0]         s_wen,
   input  logic [1:0]         s_size,
   output logic               s_ready,
   output logic [3:0]         arid,
   output logic [7:0]         arlen,
   output logic [2:0]         arsize,
   output logic [1:0]         arburst,
   output logic [A_WIDTH-1:0] araddr,
   output logic               arvalid,
   input  logic               arready,
   input  logic [31:0]        rdata,
   input  logic [1:0]         rresp,
   input  logic               rlast,
   input  logic               rvalid,
   output logic               rready,
   output logic [3:0]         awid,
   output logic [7:0]         awlen,
   output logic [2:0]         awsize,
   output logic [1:0]         awburst,
   output logic [A_WIDTH-1:0] awaddr,
   output logic               awvalid,
   input  logic               awready,
   output logic [31:0]        wdata,
   output logic [3:0]         wstrb,
   output logic               wlast,
   output logic               wvalid,
   input  logic               wready,
   input  logic [1:0]         bresp,
   input  logic               bvalid,
   output logic               bready
);

   state_t             state;
   logic [A_WIDTH-1:0] a_reg;
   logic [31:0]        din_reg;
   logic [3:0]         wen_reg;
   logic [1:0]         size_reg;
   logic               aw_done, w_done;
   logic               aw_hs, w_hs, aw_fin, w_fin;

   // Error responses complete like OKAY and are intentionally not reported.
   logic unused_resp;
   assign unused_resp = ^{rresp, bresp, RESP_OKAY};

   assign arid    = AXI_ID;
   assign awid    = AXI_ID;
   assign arlen   = '0;
   assign awlen   = '0;
   assign arburst = AXI_BURST_INCR;
   assign awburst = AXI_BURST_INCR;
   assign araddr  = a_reg;
   assign awaddr  = a_reg;
   assign arsize  = {1'b0, size_reg};
   assign awsize  = {1'b0, size_reg};
   assign wdata   = din_reg;
   assign wstrb   = wen_reg;
   assign wlast   = 1'b1;

   always_comb begin
      aw_hs  = awvalid & awready;
      w_hs   = wvalid & wready;
      aw_fin = aw_done | aw_hs;
      w_fin  = w_done | w_hs;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= S_IDLE;
         a_reg    <= '0;
         din_reg  <= '0;
         wen_reg  <= '0;
         size_reg <= '0;
         aw_done  <= 1'b0;
         w_done   <= 1'b0;
         arvalid  <= 1'b0;
         rready   <= 1'b0;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         bready   <= 1'b0;
         s_ready  <= 1'b0;
         s_dout   <= '0;
      end else begin
         s_ready <= 1'b0;
         case (state)
            // A request seen during the s_ready cycle belongs to the cache's
            // next access and is taken one cycle later.
            S_IDLE: begin
               if (s_strobe && !s_ready) begin
                  a_reg    <= s_a;
                  din_reg  <= s_din;
                  wen_reg  <= s_wen;
                  size_reg <= s_size;
                  if (s_rw) begin
                     state   <= S_WR_ADDR;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     aw_done <= 1'b0;
                     w_done  <= 1'b0;
                  end else begin
                     state   <= S_RD_ADDR;
                     arvalid <= 1'b1;
                  end
               end
            end
            S_RD_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (rvalid && rlast) begin
                  rready  <= 1'b0;
                  s_dout  <= rdata;
                  s_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            S_WR_ADDR: begin
               if (aw_hs) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               if (aw_fin && w_fin) begin
                  bready <= 1'b1;
                  state  <= S_WR_RESP;
               end
            end
            S_WR_RESP: begin
               if (bvalid) begin
                  bready  <= 1'b0;
                  s_ready <= 1'b1;
                  state   <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
